// File: rtl/regfile_scoreboard.sv
// Integer register file with write-first bypass and a pending-write scoreboard
// that produces the decode issue-stall (ioIssue_ready) and a busy-register count.
module regfile_scoreboard #(
  parameter int REG_NUM_WIDTH = 5,
  parameter int REG_WIDTH     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ioRegFile_ioRD_en,
  input  logic [REG_NUM_WIDTH-1:0] ioRegFile_ioRD_addr,
  input  logic [REG_WIDTH-1:0]     ioRegFile_ioRD_data,
  input  logic                     ioRegFile_ioRS1_en,
  input  logic [REG_NUM_WIDTH-1:0] ioRegFile_ioRS1_addr,
  output logic [REG_WIDTH-1:0]     ioRegFile_ioRS1_data,
  input  logic                     ioRegFile_ioRS2_en,
  input  logic [REG_NUM_WIDTH-1:0] ioRegFile_ioRS2_addr,
  output logic [REG_WIDTH-1:0]     ioRegFile_ioRS2_data,
  input  logic                     ioIssue_valid,
  input  logic                     ioIssue_rdEn,
  input  logic [REG_NUM_WIDTH-1:0] ioIssue_rdAddr,
  output logic                     ioIssue_ready,
  input  logic                     ioFlush,
  output logic [REG_NUM_WIDTH:0]   ioBusyCount
);

  localparam int NREG = 1 << REG_NUM_WIDTH;

  logic [REG_WIDTH-1:0]   regs_q [NREG];
  logic [NREG-1:0]        busy_q, busy_d;
  logic [REG_NUM_WIDTH:0] count_q, count_d;

  logic wr_ok;
  logic hz1, hz2, hzw, fire;

  assign wr_ok = ioRegFile_ioRD_en && (ioRegFile_ioRD_addr != '0);

  // Bypass is gated by reset so reads are 0 while reset is held.
  always_comb begin
    ioRegFile_ioRS1_data = '0;
    if (!reset && ioRegFile_ioRS1_addr != '0) begin
      if (wr_ok && ioRegFile_ioRD_addr == ioRegFile_ioRS1_addr)
        ioRegFile_ioRS1_data = ioRegFile_ioRD_data;
      else
        ioRegFile_ioRS1_data = regs_q[ioRegFile_ioRS1_addr];
    end
  end

  always_comb begin
    ioRegFile_ioRS2_data = '0;
    if (!reset && ioRegFile_ioRS2_addr != '0) begin
      if (wr_ok && ioRegFile_ioRD_addr == ioRegFile_ioRS2_addr)
        ioRegFile_ioRS2_data = ioRegFile_ioRD_data;
      else
        ioRegFile_ioRS2_data = regs_q[ioRegFile_ioRS2_addr];
    end
  end

  assign hz1 = ioRegFile_ioRS1_en && busy_q[ioRegFile_ioRS1_addr] &&
               !(ioRegFile_ioRD_en && ioRegFile_ioRD_addr == ioRegFile_ioRS1_addr);
  assign hz2 = ioRegFile_ioRS2_en && busy_q[ioRegFile_ioRS2_addr] &&
               !(ioRegFile_ioRD_en && ioRegFile_ioRD_addr == ioRegFile_ioRS2_addr);
  assign hzw = ioIssue_rdEn && busy_q[ioIssue_rdAddr] &&
               !(ioRegFile_ioRD_en && ioRegFile_ioRD_addr == ioIssue_rdAddr);

  assign ioIssue_ready = !(hz1 || hz2 || hzw);
  assign fire          = ioIssue_valid && ioIssue_ready;

  // Set is applied after clear so a new producer supersedes a same-cycle write-back.
  always_comb begin
    busy_d = busy_q;
    if (ioFlush) begin
      busy_d = '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (ioRegFile_ioRD_en && ioRegFile_ioRD_addr == REG_NUM_WIDTH'(i))
          busy_d[i] = 1'b0;
        if (fire && ioIssue_rdEn && ioIssue_rdAddr == REG_NUM_WIDTH'(i))
          busy_d[i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NREG; i++)
      count_d = count_d + {{REG_NUM_WIDTH{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok)
        regs_q[ioRegFile_ioRD_addr] <= ioRegFile_ioRD_data;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign ioBusyCount = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus pushes expected values into a
// queue tagged with the cycle they apply to; a monitor pops and compares them.
module tb_regfile_scoreboard;

  localparam int NW = 5;
  localparam int DW = 32;

  localparam int S_RS1 = 0;
  localparam int S_RS2 = 1;
  localparam int S_RDY = 2;
  localparam int S_CNT = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          rd_en;
  logic [NW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rs1_en;
  logic [NW-1:0] rs1_addr;
  logic [DW-1:0] rs1_data;
  logic          rs2_en;
  logic [NW-1:0] rs2_addr;
  logic [DW-1:0] rs2_data;
  logic          iss_valid;
  logic          iss_rden;
  logic [NW-1:0] iss_rdaddr;
  logic          iss_ready;
  logic          flush;
  logic [NW:0]   busy_cnt;

  regfile_scoreboard #(.REG_NUM_WIDTH(NW), .REG_WIDTH(DW)) dut (
    .clock                (clock),
    .reset                (reset),
    .ioRegFile_ioRD_en    (rd_en),
    .ioRegFile_ioRD_addr  (rd_addr),
    .ioRegFile_ioRD_data  (rd_data),
    .ioRegFile_ioRS1_en   (rs1_en),
    .ioRegFile_ioRS1_addr (rs1_addr),
    .ioRegFile_ioRS1_data (rs1_data),
    .ioRegFile_ioRS2_en   (rs2_en),
    .ioRegFile_ioRS2_addr (rs2_addr),
    .ioRegFile_ioRS2_data (rs2_data),
    .ioIssue_valid        (iss_valid),
    .ioIssue_rdEn         (iss_rden),
    .ioIssue_rdAddr       (iss_rdaddr),
    .ioIssue_ready        (iss_ready),
    .ioFlush              (flush),
    .ioBusyCount          (busy_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   n_run   = 0;
  int   n_fail  = 0;
  event chk_ev;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      S_RS1:   return rs1_data;
      S_RS2:   return rs2_data;
      S_RDY:   return {31'd0, iss_ready};
      default: return {26'd0, busy_cnt};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    logic [31:0] act;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      e   = exp_q.pop_front();
      act = sample(e.sig);
      n_run++;
      if (e.cyc != cyc_cnt || act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, due %0d)",
                 e.name, act, e.val, cyc_cnt, e.cyc);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock or chk_ev);
      drain();
    end
  end

  task automatic expect_v(input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rd_en = 0; rd_addr = '0; rd_data = '0;
    rs1_en = 0; rs1_addr = '0; rs2_en = 0; rs2_addr = '0;
    iss_valid = 0; iss_rden = 0; iss_rdaddr = '0; flush = 0;
  endtask

  task automatic issue(input logic [NW-1:0] rd);
    iss_valid = 1; iss_rden = 1; iss_rdaddr = rd;
  endtask

  task automatic wb(input logic [NW-1:0] a, input logic [DW-1:0] d);
    rd_en = 1; rd_addr = a; rd_data = d;
  endtask

  initial begin
    reset = 1;
    idle();
    step();
    // write during reset must not be visible through the bypass
    wb(5'd5, 32'h1111_2222); rs1_addr = 5'd5;
    expect_v(S_RS1, 32'h0, "reset_rs1");
    expect_v(S_RS2, 32'h0, "reset_rs2");
    expect_v(S_RDY, 32'd1, "reset_ready");
    expect_v(S_CNT, 32'd0, "reset_count");
    step();
    reset = 0;
    idle();

    step(); // T1
    wb(5'd5, 32'hDEAD_BEEF); rs1_addr = 5'd5;
    expect_v(S_RS1, 32'hDEAD_BEEF, "bypass_x5");
    step(); // T2
    idle(); rs1_addr = 5'd5; rs2_addr = 5'd0;
    expect_v(S_RS1, 32'hDEAD_BEEF, "read_x5");
    expect_v(S_RS2, 32'h0, "read_x0");
    step(); // T3
    idle(); wb(5'd0, 32'h1234); rs1_addr = 5'd0; issue(5'd0);
    expect_v(S_RS1, 32'h0, "x0_no_bypass");
    step(); // T4
    idle(); rs1_addr = 5'd0;
    expect_v(S_RS1, 32'h0, "x0_after_write");
    expect_v(S_CNT, 32'd0, "x0_never_busy");
    step(); // T5
    idle(); issue(5'd7);
    expect_v(S_RDY, 32'd1, "issue7_ready");
    step(); // T6
    idle(); rs1_en = 1; rs1_addr = 5'd7;
    expect_v(S_RDY, 32'd0, "raw_x7_stall");
    expect_v(S_CNT, 32'd1, "count_x7");
    step(); // T7
    wb(5'd7, 32'h55);
    expect_v(S_RDY, 32'd1, "raw_x7_wb_bypass_ready");
    expect_v(S_RS1, 32'h55, "raw_x7_wb_bypass_data");
    step(); // T8
    idle(); rs1_en = 1; rs1_addr = 5'd7;
    expect_v(S_CNT, 32'd0, "x7_cleared_count");
    expect_v(S_RDY, 32'd1, "x7_cleared_ready");
    expect_v(S_RS1, 32'h55, "x7_value");
    step(); // T9
    idle(); issue(5'd3);
    step(); // T10
    idle(); issue(5'd3); wb(5'd3, 32'hA5A5_A5A5);
    expect_v(S_CNT, 32'd1, "x3_busy_count");
    expect_v(S_RDY, 32'd1, "waw_x3_bypass_ready");
    step(); // T11
    idle(); rs2_en = 1; rs2_addr = 5'd3;
    expect_v(S_CNT, 32'd1, "set_wins_count");
    expect_v(S_RDY, 32'd0, "set_wins_stall_rs2");
    expect_v(S_RS2, 32'hA5A5_A5A5, "set_wins_data");
    step(); // T12
    idle(); wb(5'd3, 32'h77);
    expect_v(S_CNT, 32'd1, "x3_before_clear");
    step(); // T13
    idle(); issue(5'd4);
    expect_v(S_CNT, 32'd0, "x3_after_clear");
    step(); // T14
    idle(); issue(5'd9);
    expect_v(S_CNT, 32'd1, "count_after_x4");
    step(); // T15
    idle(); flush = 1; issue(5'd12); wb(5'd12, 32'hC0C0_C0C0);
    expect_v(S_CNT, 32'd2, "count_x4_x9");
    step(); // T16
    idle(); iss_valid = 1; rs1_en = 1; rs1_addr = 5'd4; rs2_addr = 5'd12;
    expect_v(S_CNT, 32'd0, "flush_count");
    expect_v(S_RDY, 32'd1, "flush_rs1_x4_ready");
    expect_v(S_RS2, 32'hC0C0_C0C0, "flush_keeps_write");
    step(); // T17
    idle(); issue(5'd10);
    expect_v(S_CNT, 32'd0, "flush_ignored_issue");
    step(); // T18
    idle(); rs1_en = 1; rs1_addr = 5'd10; rs2_addr = 5'd5;
    expect_v(S_CNT, 32'd1, "count_x10");
    expect_v(S_RDY, 32'd0, "x10_stall");
    expect_v(S_RS2, 32'hDEAD_BEEF, "x5_before_reset");
    step(); // T19: async reset between edges
    #2;
    reset = 1;
    #1;
    expect_v(S_RDY, 32'd1, "async_rst_ready");
    expect_v(S_CNT, 32'd0, "async_rst_count");
    expect_v(S_RS2, 32'h0, "async_rst_rs2");
    ->chk_ev;
    #1;
    step();
    step();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_run++;
      n_fail++;
      $display("FAIL %s: never checked, expected 0x%08h", e.name, e.val);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
